// File: rtl/l2_cacheline_adaptor.sv
// l2_cacheline_adaptor
//   Turns single-line L2 read/write requests into fixed-length bursts on the
//   physical-memory side. Read beats are assembled into a full line, and
//   write-back lines are sent out one beat at a time. The L2 gets a one-cycle
//   line_resp when the whole line has transferred.
//
// Ports
//   clk            clock, rising edge
//   rst            asynchronous active-low reset
//   line_address   L2 request address (byte address; offset bits ignored)
//   line_read      L2 line read request, held until line_resp
//   line_write     L2 line write request, held until line_resp
//   line_wdata     line to write back
//   line_rdata     assembled read line (line buffer)
//   line_resp      one-cycle completion pulse
//   burst_address  line-aligned memory address, 0 when idle
//   burst_read     memory read request
//   burst_write    memory write request
//   burst_wdata    current write beat, 0 outside a write burst
//   burst_rdata    read beat from memory
//   burst_resp     per-beat handshake from memory
//
// States
//   IDLE | waiting for a request; requests are sampled only here
//   RD   | read burst in progress, one beat per burst_resp
//   WR   | write burst in progress, one beat per burst_resp
//   DONE | line_resp pulse, memory request dropped

module l2_cacheline_adaptor #(
  parameter int s_offset = 5,
  parameter int s_line   = 256,
  parameter int s_burst  = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         line_address,
  input  logic                line_read,
  input  logic                line_write,
  input  logic [s_line-1:0]   line_wdata,
  output logic [s_line-1:0]   line_rdata,
  output logic                line_resp,
  output logic [31:0]         burst_address,
  output logic                burst_read,
  output logic                burst_write,
  output logic [s_burst-1:0]  burst_wdata,
  input  logic [s_burst-1:0]  burst_rdata,
  input  logic                burst_resp
);

  localparam int nb    = s_line / s_burst;
  localparam int cnt_w = (nb > 1) ? $clog2(nb) : 1;
  localparam logic [cnt_w-1:0] last_beat = cnt_w'(nb - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [cnt_w-1:0]            beat_cnt;
  logic [31-s_offset:0]        line_tag;
  logic [nb-1:0][s_burst-1:0]  line_buf;
  logic [31:0]                 aligned_addr;
  logic                        last_handshake;

  // Byte-offset bits of the request never reach memory.
  logic unused_offset_bits;
  assign unused_offset_bits = ^line_address[s_offset-1:0];

  assign aligned_addr   = {line_tag, {s_offset{1'b0}}};
  assign last_handshake = burst_resp && (beat_cnt == last_beat);
  assign line_rdata     = line_buf;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    burst_read    = 1'b0;
    burst_write   = 1'b0;
    line_resp     = 1'b0;
    burst_wdata   = '0;
    burst_address = '0;
    case (state)
      IDLE: begin
        // Read has priority when both requests are raised together.
        if (line_read) begin
          state_nxt = RD;
        end else if (line_write) begin
          state_nxt = WR;
        end
      end
      RD: begin
        burst_read    = 1'b1;
        burst_address = aligned_addr;
        if (last_handshake) begin
          state_nxt = DONE;
        end
      end
      WR: begin
        burst_write   = 1'b1;
        burst_address = aligned_addr;
        burst_wdata   = line_buf[beat_cnt];
        if (last_handshake) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        line_resp     = 1'b1;
        burst_address = aligned_addr;
        state_nxt     = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Beat counter, latched line address and the shared line buffer. The buffer
  // doubles as write-back source and read assembly area; beat 0 is the LSBs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_cnt <= '0;
      line_tag <= '0;
      line_buf <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (line_read) begin
            line_tag <= line_address[31:s_offset];
          end else if (line_write) begin
            line_tag <= line_address[31:s_offset];
            line_buf <= line_wdata;
          end
        end
        RD: begin
          if (burst_resp) begin
            line_buf[beat_cnt] <= burst_rdata;
            beat_cnt           <= (beat_cnt == last_beat) ? '0 : beat_cnt + 1'b1;
          end
        end
        WR: begin
          if (burst_resp) begin
            beat_cnt <= (beat_cnt == last_beat) ? '0 : beat_cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l2_cacheline_adaptor.sv
module tb_l2_cacheline_adaptor;

  logic         clk;
  logic         rst;
  logic [31:0]  line_address;
  logic         line_read;
  logic         line_write;
  logic [255:0] line_wdata;
  logic [255:0] line_rdata;
  logic         line_resp;
  logic [31:0]  burst_address;
  logic         burst_read;
  logic         burst_write;
  logic [63:0]  burst_wdata;
  logic [63:0]  burst_rdata;
  logic         burst_resp;

  l2_cacheline_adaptor dut (
    .clk           (clk),
    .rst           (rst),
    .line_address  (line_address),
    .line_read     (line_read),
    .line_write    (line_write),
    .line_wdata    (line_wdata),
    .line_rdata    (line_rdata),
    .line_resp     (line_resp),
    .burst_address (burst_address),
    .burst_read    (burst_read),
    .burst_write   (burst_write),
    .burst_wdata   (burst_wdata),
    .burst_rdata   (burst_rdata),
    .burst_resp    (burst_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         is_read;
    logic [31:0]  addr;
    logic [255:0] line;
    int           resp_cyc;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] wbeat_q[$];
  logic [63:0] rdat_q[$];
  int          stall_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int n_issued = 0;
  int n_resp = 0;
  bit spurious = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s at cycle %0d", nm, cyc);
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // Memory model: per beat, wait the queued number of stall cycles, then
  // hand over one beat. Spurious handshakes are injected only on request.
  always @(posedge clk) begin
    #1;
    burst_resp  = 1'b0;
    burst_rdata = 64'h0;
    if (!rst) begin
      burst_resp = 1'b0;
    end else if ((burst_read || burst_write) && stall_q.size() > 0) begin
      if (stall_q[0] > 0) begin
        stall_q[0] = stall_q[0] - 1;
      end else begin
        void'(stall_q.pop_front());
        burst_resp = 1'b1;
        if (burst_read && rdat_q.size() > 0) burst_rdata = rdat_q.pop_front();
        else burst_rdata = {$urandom, $urandom};
      end
    end else if (spurious) begin
      burst_resp  = 1'b1;
      burst_rdata = {$urandom, $urandom};
    end
  end

  // Monitor: checks every memory-side cycle and every line_resp against the
  // scoreboard head.
  always @(negedge clk) begin
    if (burst_read || burst_write) begin
      if (sb.size() == 0) begin
        fail_now("unexpected_burst");
      end else begin
        check("burst_address", 256'(burst_address), 256'(sb[0].addr));
        check("burst_dir", 256'({burst_read, burst_write}),
              256'(sb[0].is_read ? 2'b10 : 2'b01));
        if (burst_write && !sb[0].is_read) begin
          if (wbeat_q.size() == 0) begin
            fail_now("extra_write_beat");
          end else begin
            check("burst_wdata", 256'(burst_wdata), 256'(wbeat_q[0]));
            if (burst_resp) void'(wbeat_q.pop_front());
          end
        end
      end
    end
    if (line_resp) begin
      n_resp++;
      if (sb.size() == 0) begin
        fail_now("unexpected_line_resp");
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("resp_cycle", 256'(cyc), 256'(e.resp_cyc));
        check("burst_dir_at_resp", 256'({burst_read, burst_write}), 256'(0));
        if (e.is_read) check("line_rdata", line_rdata, e.line);
      end
    end
  end

  task automatic clear_model();
    sb.delete();
    wbeat_q.delete();
    rdat_q.delete();
    stall_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    line_read = 1'b0;
    line_write = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic check_outputs_zero(input string nm);
    check({nm, "_ctl"}, 256'({line_resp, burst_read, burst_write, burst_address, burst_wdata}), 256'(0));
    check({nm, "_rdata"}, line_rdata, 256'(0));
  endtask

  // Issues one request (caller is at posedge+1 with the DUT idle), waits for
  // its completion and drops the request the following cycle.
  task automatic do_txn(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [255:0] wline, input logic [255:0] mline,
                        input logic [7:0] stl);
    exp_t e;
    int tot;
    int waited;
    tot = 0;
    for (int i = 0; i < 4; i++) begin
      stall_q.push_back(int'(stl[2*i +: 2]));
      tot += int'(stl[2*i +: 2]);
    end
    e.is_read  = rd;
    e.addr     = addr & 32'hFFFF_FFE0;
    e.line     = mline;
    e.resp_cyc = cyc + 5 + tot;
    for (int i = 0; i < 4; i++) begin
      if (rd) rdat_q.push_back(mline[64*i +: 64]);
      else    wbeat_q.push_back(wline[64*i +: 64]);
    end
    sb.push_back(e);
    n_issued++;
    line_address = addr;
    line_wdata   = wline;
    line_read    = rd;
    line_write   = wr;
    @(posedge clk);
    #1;
    line_address = $urandom;
    line_wdata   = rand256();
    waited = 0;
    while (!line_resp && waited < 60) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (waited >= 60) begin
      fail_now("line_resp_timeout");
      do_reset();
    end else begin
      @(posedge clk);
      #1;
      line_read  = 1'b0;
      line_write = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  logic [255:0] rd_line;
  logic [255:0] wr_line;

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    line_address = 32'h0;
    line_read = 1'b0;
    line_write = 1'b0;
    line_wdata = '0;
    burst_rdata = 64'h0;
    burst_resp = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset_state");
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Directed read, no stalls.
    rd_line = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
               64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    do_txn(1'b1, 1'b0, 32'h1234_567F, rand256(), rd_line, 8'h00);

    // Spurious handshakes while idle: buffer and state must not move.
    spurious = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    spurious = 1'b0;
    check("spurious_rdata", line_rdata, rd_line);
    check("spurious_ctl", 256'({line_resp, burst_read, burst_write}), 256'(0));
    @(posedge clk);
    #1;

    // Directed write, two stall cycles before beat 2.
    wr_line = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
               64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    do_txn(1'b0, 1'b1, 32'h0000_1040, wr_line, '0, 8'b0010_0000);

    // Both requests together: read wins.
    do_txn(1'b1, 1'b1, 32'h0ABC_0008, rand256(), rand256(), 8'h00);

    // Reset after beat 2 of a read.
    begin
      exp_t e;
      e.is_read = 1'b1;
      e.addr = 32'h5555_0000;
      e.line = '0;
      e.resp_cyc = cyc + 5;
      sb.push_back(e);
      for (int i = 0; i < 4; i++) begin
        stall_q.push_back(0);
        rdat_q.push_back({$urandom, $urandom});
      end
      line_address = 32'h5555_0000;
      line_read = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b0;
      line_read = 1'b0;
      clear_model();
      #1;
      check_outputs_zero("mid_reset");
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
    end
    n_issued = 0;
    n_resp = 0;
    do_txn(1'b1, 1'b0, 32'h7777_00E0, rand256(), rand256(), 8'b0001_0100);

    // Back-to-back write then read to different lines.
    do_txn(1'b0, 1'b1, 32'h2000_0000, rand256(), '0, 8'h00);
    do_txn(1'b1, 1'b0, 32'h3000_0020, rand256(), rand256(), 8'h00);

    // Random mix.
    for (int t = 0; t < 25; t++) begin
      logic [1:0] op;
      op = 2'($urandom_range(1, 3));
      do_txn(op[0], op[1], $urandom, rand256(), rand256(), 8'($urandom));
    end

    repeat (3) @(posedge clk);
    #1;
    check("resp_count", 256'(n_resp), 256'(n_issued));
    check("scoreboard_empty", 256'(sb.size()), 256'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
